mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives CORE_COUNT cores shared access to one single-port RAM.
// Grants are combinational. Read-valid flags are registered to line up with the RAM's one-cycle read latency.
module mem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            req,
  input  logic [CORE_COUNT-1:0]            wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [CORE_COUNT*WIDTH-1:0]      dataIn,
  output logic [CORE_COUNT-1:0]            gnt,
  output logic [CORE_COUNT-1:0]            rdValid,
  output logic [WIDTH-1:0]                 dataOut,
  output logic                             ram_wrEn,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [WIDTH-1:0]                 ram_dataIn,
  input  logic [WIDTH-1:0]                 ram_dataOut
);

  localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CORE_COUNT-1:0] rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand_idx;
  logic                  gnt_any;
  int                    cand;

  logic [ADDR_WIDTH-1:0] addr_arr [CORE_COUNT];
  logic [WIDTH-1:0]      data_arr [CORE_COUNT];

  generate
    for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_unpack
      assign addr_arr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = dataIn[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search from ptr upward with wraparound. Reset masks every grant so nothing leaks out while rst is high.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= CORE_COUNT) cand = cand - CORE_COUNT;
      cand_idx = PTR_W'(cand);
      if (!gnt_any && !rst && req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign ram_wrEn   = gnt_any & wrEn[gnt_idx];
  assign ram_addr   = addr_arr[gnt_idx];
  assign ram_dataIn = data_arr[gnt_idx];
  assign dataOut    = ram_dataOut;
  assign rdValid    = rd_valid_q;

  always_comb begin
    ptr_d      = ptr_q;
    rd_valid_d = '0;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(CORE_COUNT - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (!wrEn[gnt_idx]) rd_valid_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. It includes a one-cycle-latency RAM model driven by the arbiter's RAM port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, wrEn;
  logic [31:0] addr;
  logic [47:0] dataIn;
  logic [3:0]  gnt, rdValid;
  logic [11:0] dataOut;
  logic        ram_wrEn;
  logic [7:0]  ram_addr;
  logic [11:0] ram_dataIn;
  logic [11:0] ram_dataOut;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [11:0] pre_data;
  logic [11:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wrEn(wrEn), .addr(addr), .dataIn(dataIn),
    .gnt(gnt), .rdValid(rdValid), .dataOut(dataOut), .ram_wrEn(ram_wrEn),
    .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic set_core(input int k, input logic we, input logic [7:0] a, input logic [11:0] d);
    wrEn[k] = we;
    addr[k*8 +: 8] = a;
    dataIn[k*12 +: 12] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; wrEn = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req = 4'hF; wrEn = 4'hF;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (ram_wrEn !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wrEn got %b want 0", ram_wrEn); end
    n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL reset_rdValid got %b want 0000", rdValid); end
    $display("reset: gnt=%b ram_wrEn=%b rdValid=%b", gnt, ram_wrEn, rdValid);
    @(negedge clk);
    rst = 1'b0; req = '0; wrEn = '0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_core(0, 1'b0, 8'h10, 12'h000);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL read_gnt got %b want 0001", gnt); end
    n_cmp++; if (ram_addr !== 8'h10) begin n_fail++; $display("FAIL read_ram_addr got %h want 10", ram_addr); end
    n_cmp++; if (ram_wrEn !== 1'b0) begin n_fail++; $display("FAIL read_ram_wrEn got %b want 0", ram_wrEn); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rdValid !== 4'b0001) begin n_fail++; $display("FAIL read_rdValid got %b want 0001", rdValid); end
    n_cmp++; if (dataOut !== 12'hABC) begin n_fail++; $display("FAIL read_dataOut got %h want abc", dataOut); end
    $display("read core0 addr 10: rdValid=%b dataOut=%h", rdValid, dataOut);
    @(negedge clk);
    #1;
    n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL read_rdValid_drop got %b want 0000", rdValid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [3:0] prev_gnt;
    do_reset();
    prev_gnt = 4'b0000;
    for (int k = 0; k < 4; k++) set_core(k, 1'b0, 8'(k), 12'h000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 4'hF;
      #1;
      exp_gnt = 4'(1 << (i % 4));
      n_cmp++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", i, gnt, exp_gnt); end
      n_cmp++; if (rdValid !== prev_gnt) begin n_fail++; $display("FAIL rr_rdValid[%0d] got %b want %b", i, rdValid, prev_gnt); end
      $display("rr cycle %0d: gnt=%b rdValid=%b", i, gnt, rdValid);
      prev_gnt = exp_gnt;
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    req = 4'b0000; wrEn = '0;
    set_core(2, 1'b1, 8'h20, 12'h5A5);
    req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt got %b want 0100", gnt); end
    n_cmp++; if (ram_wrEn !== 1'b1) begin n_fail++; $display("FAIL wr_ram_wrEn got %b want 1", ram_wrEn); end
    n_cmp++; if (ram_addr !== 8'h20) begin n_fail++; $display("FAIL wr_ram_addr got %h want 20", ram_addr); end
    n_cmp++; if (ram_dataIn !== 12'h5A5) begin n_fail++; $display("FAIL wr_ram_dataIn got %h want 5a5", ram_dataIn); end
    $display("write core2 addr 20 data 5a5: gnt=%b", gnt);
    @(negedge clk);
    set_core(2, 1'b0, 8'h00, 12'h000);
    set_core(0, 1'b0, 8'h20, 12'h000);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_gnt got %b want 0001", gnt); end
    n_cmp++; if (ram_wrEn !== 1'b0) begin n_fail++; $display("FAIL wr_rd_ram_wrEn got %b want 0", ram_wrEn); end
    n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL wr_no_rdValid got %b want 0000", rdValid); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rdValid !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_rdValid got %b want 0001", rdValid); end
    n_cmp++; if (dataOut !== 12'h5A5) begin n_fail++; $display("FAIL wr_rd_dataOut got %h want 5a5", dataOut); end
    $display("read core0 addr 20: rdValid=%b dataOut=%h", rdValid, dataOut);
  endtask

  task automatic test_wrap();
    // Pointer is 1 here. A read by core 2 moves it to 3.
    @(negedge clk);
    set_core(2, 1'b0, 8'h30, 12'h000);
    req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_pre_gnt got %b want 0100", gnt); end
    @(negedge clk);
    set_core(0, 1'b1, 8'h40, 12'h111);
    set_core(3, 1'b1, 8'h41, 12'h333);
    req = 4'b1001;
    #1;
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt3 got %b want 1000", gnt); end
    n_cmp++; if (rdValid !== 4'b0100) begin n_fail++; $display("FAIL wrap_rdValid got %b want 0100", rdValid); end
    @(negedge clk);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0 got %b want 0001", gnt); end
    n_cmp++; if (ram_addr !== 8'h40) begin n_fail++; $display("FAIL wrap_ram_addr got %h want 40", ram_addr); end
    $display("wrap: gnt=%b ram_addr=%h", gnt, ram_addr);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 4'b0000; wrEn = 4'hF;
      #1;
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt[%0d] got %b want 0000", i, gnt); end
      n_cmp++; if (ram_wrEn !== 1'b0) begin n_fail++; $display("FAIL idle_ram_wrEn[%0d] got %b want 0", i, ram_wrEn); end
      n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL idle_rdValid[%0d] got %b want 0000", i, rdValid); end
    end
    // Pointer should still be 1, so with everyone requesting core 1 wins.
    @(negedge clk);
    wrEn = 4'hF; req = 4'hF;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL idle_ptr_hold got %b want 0010", gnt); end
    $display("idle x5 then all req: gnt=%b", gnt);
  endtask

  task automatic test_reset_mid_read();
    // Pointer is 2 here, so a lone request from core 1 wins after a wrap.
    @(negedge clk);
    wrEn = '0;
    set_core(1, 1'b0, 8'h10, 12'h000);
    req = 4'b0010;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0010", gnt); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt_forced got %b want 0000", gnt); end
    @(negedge clk);
    n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rdValid got %b want 0000", rdValid); end
    rst = 1'b0;
    req = 4'b0110;
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_resume got %b want 0010", gnt); end
    n_cmp++; if (rdValid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rdValid_post got %b want 0000", rdValid); end
    $display("reset mid-read: resume gnt=%b rdValid=%b", gnt, rdValid);
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rdValid !== 4'b0010) begin n_fail++; $display("FAIL rstmid_read_done got %b want 0010", rdValid); end
  endtask

  initial begin
    rst = 1'b1; req = '0; wrEn = '0; addr = '0; dataIn = '0;
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 12'hABC;
    @(negedge clk);
    pre_we = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_wrap();
    test_idle();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
